// File: rtl/imem_fetch_ctrl_if.sv
// imem_fetch_ctrl_if: signal bundle between the instruction fetch controller,
// its instruction memory, the decode stage and the debug reader.
// master = fetch controller, slave = surrounding system.
interface imem_fetch_ctrl_if;
  logic [31:0] imem_a;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;

  modport master (
    output imem_a,
    input  imem_rd,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_pc,
    input  dbg_req,
    input  dbg_addr,
    output dbg_ack,
    output dbg_rdata
  );

  modport slave (
    input  imem_a,
    output imem_rd,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_pc,
    output dbg_req,
    output dbg_addr,
    input  dbg_ack,
    input  dbg_rdata
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction fetch front end for a synchronous-read imem
// (one cycle read latency). Responses land in a 2-entry FIFO that feeds the
// consumer through a valid/ready handshake; redirects flush everything.
// Optional debug read port shares the imem address port; it is compiled only
// when IMEM_FETCH_DBG_EN is defined, otherwise fetch owns every slot.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_RUN      | normal fetch issue, debug/fetch arbitration on the imem port
// ST_DBG_WAIT | debug read data returns this cycle, dbg_ack high, no new grant
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 64
) (
  input  logic              clka,
  input  logic              rst_n,
  imem_fetch_ctrl_if.master bus
);

  localparam logic [31:0] PC_WRAP    = 32'(IMEM_DEPTH * 4);
  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_inc;
  logic [31:0] fetch_pc_nxt;
  logic [31:0] fifo_data [2];
  logic [31:0] fifo_pc   [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        inflight;
  logic [31:0] rsp_pc;
  logic        redirect;
  logic        pop;
  logic        push;
  logic [2:0]  occupancy;
  logic        fetch_ok;
  logic        fetch_issue;

  assign redirect     = bus.redirect_valid;
  assign bus.inst_valid = (count != 2'd0);
  assign bus.inst     = fifo_data[rd_ptr];
  assign bus.inst_pc  = fifo_pc[rd_ptr];

  // Redirect wins over both pop and push: the head is not consumed and the
  // response arriving in the redirect cycle is the discarded in-flight word.
  assign pop  = bus.inst_valid && bus.inst_ready && !redirect;
  assign push = inflight && !redirect;

  // Occupancy is taken net of this cycle's pop so a streaming consumer sees
  // one instruction per cycle; count + inflight never exceeds 2.
  assign occupancy = {1'b0, count} - {2'b00, pop} + {2'b00, inflight};
  assign fetch_ok  = !redirect && (occupancy < 3'd2);

  assign fetch_pc_inc = fetch_pc + 32'd4;
  assign fetch_pc_nxt = (fetch_pc_inc >= PC_WRAP) ? 32'd0 : fetch_pc_inc;

`ifdef IMEM_FETCH_DBG_EN
  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_DBG_WAIT = 1'b1;

  logic [0:0] state;
  logic       last_dbg;
  logic       dbg_grant;
  logic [1:0] unused_bits;

  // Debug wins the port unless it also had the previous slot and fetch wants it.
  assign dbg_grant   = rst_n && bus.dbg_req && (state == ST_RUN) && !(last_dbg && fetch_ok);
  assign fetch_issue = fetch_ok && !dbg_grant;
  assign bus.dbg_ack   = rst_n && (state == ST_DBG_WAIT);
  assign bus.dbg_rdata = bus.dbg_ack ? bus.imem_rd : 32'd0;
  assign bus.imem_a    = !rst_n    ? RESET_PC_W :
                         dbg_grant ? {bus.dbg_addr[31:2], 2'b00} : fetch_pc;
  assign unused_bits   = bus.redirect_pc[1:0] ^ bus.dbg_addr[1:0];

  // Debug handshake FSM and last-grant tracking for alternation.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      last_dbg <= 1'b0;
    end else begin
      case (state)
        ST_RUN:      if (dbg_grant)   state <= ST_DBG_WAIT;
        ST_DBG_WAIT: if (bus.dbg_ack) state <= ST_RUN;
        default:                      state <= ST_RUN;
      endcase
      if (dbg_grant) begin
        last_dbg <= 1'b1;
      end else if (fetch_issue) begin
        last_dbg <= 1'b0;
      end
    end
  end
`else
  logic unused_dbg;

  assign fetch_issue   = fetch_ok;
  assign bus.dbg_ack   = 1'b0;
  assign bus.dbg_rdata = 32'd0;
  assign bus.imem_a    = rst_n ? fetch_pc : RESET_PC_W;
  assign unused_dbg    = ^{bus.dbg_req, bus.dbg_addr, bus.redirect_pc[1:0]};
`endif

  // Fetch PC, in-flight tracking and response FIFO.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC_W;
      inflight <= 1'b0;
      rsp_pc   <= 32'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= 32'd0;
        fifo_pc[i]   <= 32'd0;
      end
    end else if (redirect) begin
      fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (fetch_issue) begin
        fetch_pc <= fetch_pc_nxt;
        rsp_pc   <= fetch_pc;
      end
      inflight <= fetch_issue;
      if (push) begin
        fifo_data[wr_ptr] <= bus.imem_rd;
        fifo_pc[wr_ptr]   <= rsp_pc;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed + randomized bench for imem_fetch_ctrl.
// Reference: the accepted instruction stream must be the address sequence
// start, start+4, ... modulo 256 restarting at each redirect target, with
// words taken from the bench ROM. Debug sections need IMEM_FETCH_DBG_EN.
module tb_imem_fetch_ctrl;

  logic clka = 1'b0;
  logic rst_n = 1'b0;

  imem_fetch_ctrl_if bus();

  imem_fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_DEPTH (64)
  ) dut (
    .clka  (clka),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clka = ~clka;

  logic [31:0] rom [64];

  // Synchronous-read imem: word for the presented address one cycle later.
  always @(posedge clka) bus.imem_rd <= rom[bus.imem_a[7:2]];

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_xfer = 0;
  int          n_ack = 0;
  logic [31:0] exp_pc = 32'd0;
  logic [31:0] last_pc = 32'd0;
  bit          after_redirect = 1'b0;
  bit          expect_valid = 1'b0;
  bit          got_ack = 1'b0;
  bit          wrap_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check at the falling edge, advance the model, return 1 after
  // the next rising edge so the caller can drive new inputs.
  task automatic cycle();
    @(negedge clka);
    got_ack = 1'b0;
    if (rst_n) begin
      if (after_redirect) chk("valid_after_redirect", 32'(bus.inst_valid), 32'd0);
      after_redirect = 1'b0;
      if (expect_valid) chk("stream_valid", 32'(bus.inst_valid), 32'd1);
`ifndef IMEM_FETCH_DBG_EN
      chk("dbg_ack_off", 32'(bus.dbg_ack), 32'd0);
      chk("dbg_rdata_off", bus.dbg_rdata, 32'd0);
`endif
      if (bus.dbg_ack) begin
        got_ack = 1'b1;
        n_ack++;
        chk("ack_with_req", 32'(bus.dbg_req), 32'd1);
        chk("dbg_rdata", bus.dbg_rdata, rom[bus.dbg_addr[7:2]]);
      end
      if (bus.redirect_valid) begin
        exp_pc = {bus.redirect_pc[31:2], 2'b00};
        after_redirect = 1'b1;
      end else if (bus.inst_valid && bus.inst_ready) begin
        chk("inst_pc", bus.inst_pc, exp_pc);
        chk("inst", bus.inst, rom[exp_pc[7:2]]);
        if (n_xfer > 0 && last_pc == 32'h0000_00FC && bus.inst_pc == 32'd0) wrap_seen = 1'b1;
        last_pc = bus.inst_pc;
        exp_pc = (exp_pc + 32'd4) % 32'd256;
        n_xfer++;
      end else if (bus.inst_valid) begin
        chk("held_pc", bus.inst_pc, exp_pc);
      end
    end
    @(posedge clka);
    #1;
  endtask

  task automatic check_reset_outputs();
    @(negedge clka);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
    chk("rst_dbg_ack", 32'(bus.dbg_ack), 32'd0);
    chk("rst_dbg_rdata", bus.dbg_rdata, 32'd0);
    chk("rst_imem_a", bus.imem_a, 32'd0);
    @(posedge clka);
    #1;
  endtask

  // Release reset: nothing valid in the issue and response cycles.
  task automatic release_check();
    rst_n = 1'b1;
    exp_pc = 32'd0;
    after_redirect = 1'b0;
    @(negedge clka);
    chk("rel_c0_valid", 32'(bus.inst_valid), 32'd0);
    chk("rel_c0_imem_a", bus.imem_a, 32'd0);
    @(posedge clka);
    #1;
    @(negedge clka);
    chk("rel_c1_valid", 32'(bus.inst_valid), 32'd0);
    @(posedge clka);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    expect_valid = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = pc;
    cycle();
    bus.redirect_valid = 1'b0;
    cycle();
    cycle();
    expect_valid = 1'b1;
  endtask

  int x0;
  int dbg_wait;

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    bus.inst_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.dbg_req = 1'b0;
    bus.dbg_addr = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clka);
    #1;
    check_reset_outputs();

    // Streaming from reset: pc 0,4,8,... every cycle from cycle 2.
    release_check();
    expect_valid = 1'b1;
    repeat (10) cycle();

    // Back-pressure for 5 cycles, head held, then gapless resume.
    bus.inst_ready = 1'b0;
    repeat (5) cycle();
    bus.inst_ready = 1'b1;
    x0 = n_xfer;
    repeat (8) cycle();
    chk("resume_count", 32'(n_xfer - x0), 32'd8);

    // Redirect with misaligned target; stale words must never appear.
    redirect_to(32'h0000_0043);
    x0 = n_xfer;
    repeat (6) cycle();
    chk("redirect_xfers", 32'(n_xfer - x0), 32'd6);

    // Wrap at the top of the 64-word imem.
    wrap_seen = 1'b0;
    redirect_to(32'h0000_00F0);
    repeat (8) cycle();
    chk("wrap_seen", 32'(wrap_seen), 32'd1);

    // Debug read during streaming.
    x0 = n_ack;
    bus.dbg_req = 1'b1;
    bus.dbg_addr = 32'h0000_0013;
`ifdef IMEM_FETCH_DBG_EN
    expect_valid = 1'b0;
    cycle();
    chk("dbg_no_early_ack", 32'(got_ack), 32'd0);
    cycle();
    chk("dbg_ack_next", 32'(got_ack), 32'd1);
    bus.dbg_req = 1'b0;
    repeat (4) cycle();
    chk("dbg_single_ack", 32'(n_ack - x0), 32'd1);
    expect_valid = 1'b1;
    repeat (6) cycle();
`else
    repeat (4) cycle();
    bus.dbg_req = 1'b0;
    chk("dbg_no_ack", 32'(n_ack - x0), 32'd0);
`endif

    // Randomized traffic.
    expect_valid = 1'b0;
    x0 = n_xfer;
    dbg_wait = 0;
    for (int c = 0; c < 300; c++) begin
      bus.inst_ready = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      bus.redirect_pc = 32'($urandom_range(0, 255));
`ifdef IMEM_FETCH_DBG_EN
      if (!bus.dbg_req && $urandom_range(0, 7) == 0) begin
        bus.dbg_req = 1'b1;
        bus.dbg_addr = 32'($urandom_range(0, 255));
        dbg_wait = 0;
      end
`endif
      cycle();
      if (bus.dbg_req) dbg_wait++;
      if (got_ack) begin
        chk("dbg_latency", 32'(dbg_wait <= 3), 32'd1);
        bus.dbg_req = 1'b0;
        dbg_wait = 0;
      end
    end
    bus.redirect_valid = 1'b0;
    bus.inst_ready = 1'b1;
    chk("dbg_not_stuck", 32'(dbg_wait <= 3), 32'd1);
    chk("random_progress", 32'((n_xfer - x0) >= 60), 32'd1);

    // Reset mid-stream with a debug read pending.
    redirect_to(32'h0000_0000);
    repeat (3) cycle();
    x0 = n_ack;
    bus.dbg_req = 1'b1;
    bus.dbg_addr = 32'h0000_0020;
    expect_valid = 1'b0;
    cycle();
    rst_n = 1'b0;
    @(negedge clka);
    chk("no_ack_in_reset", 32'(bus.dbg_ack), 32'd0);
    @(posedge clka);
    #1;
    bus.dbg_req = 1'b0;
    check_reset_outputs();
    release_check();
    expect_valid = 1'b1;
    repeat (6) cycle();
    chk("no_ack_after_reset", 32'(n_ack - x0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
